// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the execute stage and a
// word-organised data memory (combinational read, write on the clock edge).
// Byte/half/word requests become word-aligned accesses; sub-word loads are
// extracted and extended, and sub-word stores are done as read-modify-write.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i, req_size_i     store/load select, size (00 B, 01 H, 10 W, 11 illegal)
//   req_unsigned_i           zero-extend sub-word loads
//   req_addr_i, req_wdata_i  byte address, right-aligned store data
//   resp_valid_o/resp_err_o  one-cycle completion pulse and its error flag
//   resp_rdata_o             load result (0 for stores and errors)
//   mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o, mem_rdata_i  memory side
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter bit RMW_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [31:0]       resp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] ST_WORD = 3'd2;
  localparam logic [2:0] RMW_RD  = 3'd3;
  localparam logic [2:0] RMW_WR  = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [1:0]        addr_lo;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [15:0]       wdata_q;
  logic              accept;
  logic              acc_err;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Pick the addressed lane out of a memory word and sign/zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lo,
                                          input logic [1:0] size, input logic uns);
    logic [4:0]  shamt;
    logic [31:0] sh;
    logic [31:0] res;
    shamt = 5'd0;
    case (size)
      2'b00:   shamt = {lo, 3'b000};
      2'b01:   shamt = {lo[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    sh = word >> shamt;
    case (size)
      2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
      2'b10:   res = sh;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of the old word with new store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] lo,
                                        input logic [1:0] size, input logic [15:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        ins  = {24'd0, data[7:0]} << {lo, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        ins  = {16'd0, data} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'd0;
        ins  = 32'd0;
      end
    endcase
    return (word & ~mask) | (ins & mask);
  endfunction

  assign req_ready_o = (state == IDLE) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

  // Memory strobes are decoded from state and gated by reset so that no
  // write can slip out in a cycle where reset is asserted.
  assign mem_re_o = ~rst_i & ((state == LOAD) | (state == RMW_RD));
  assign mem_we_o = ~rst_i & ((state == ST_WORD) | (state == RMW_WR));

  assign resp_valid_o = resp_valid;
  assign resp_err_o   = resp_err;
  assign resp_rdata_o = resp_rdata;
  assign mem_addr_o   = mem_addr;
  assign mem_wdata_o  = mem_wdata;

  // Classify the incoming request as misaligned, illegal or disallowed.
  always_comb begin
    acc_err = 1'b0;
    if (req_size_i == 2'b11) begin
      acc_err = 1'b1;
    end else if ((req_size_i == 2'b01) && req_addr_i[0]) begin
      acc_err = 1'b1;
    end else if ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end else if (req_we_i && (req_size_i != 2'b10) && (RMW_EN == 1'b0)) begin
      acc_err = 1'b1;
    end else begin
      acc_err = 1'b0;
    end
  end

  // Next-state decode for the access sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!accept)                  next_state = IDLE;
        else if (acc_err)             next_state = RESP;
        else if (!req_we_i)           next_state = LOAD;
        else if (req_size_i == 2'b10) next_state = ST_WORD;
        else                          next_state = RMW_RD;
      end
      LOAD:    next_state = RESP;
      ST_WORD: next_state = RESP;
      RMW_RD:  next_state = RMW_WR;
      RMW_WR:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, captured request fields and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_lo    <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 16'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
    end else begin
      state      <= next_state;
      resp_valid <= (next_state == RESP);
      if (accept) begin
        addr_lo <= req_addr_i[1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i[15:0];
        // Error requests never touch memory, so the memory address holds.
        if (!acc_err) begin
          mem_addr <= {req_addr_i[ADDR_W-1:2], 2'b00};
        end
        if (!acc_err && req_we_i && (req_size_i == 2'b10)) begin
          mem_wdata <= req_wdata_i;
        end
      end
      case (state)
        IDLE: begin
          if (accept && acc_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end
        end
        LOAD:    resp_rdata <= extract(mem_rdata_i, addr_lo, size_q, uns_q);
        ST_WORD: resp_rdata <= 32'd0;
        // The merged word is built from the old word read in this cycle.
        RMW_RD:  mem_wdata <= merge(mem_rdata_i, addr_lo, size_q, wdata_q);
        RMW_WR:  resp_rdata <= 32'd0;
        RESP:    resp_err <= 1'b0;
        default: resp_err <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_waddr = 32'd0;
  int          checks = 0;
  int          failures = 0;

  lsu_mem_ctrl #(.ADDR_W(32), .RMW_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  // Memory model: preload, edge-triggered write, strobe counters.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[8] = 32'h1122_3344;
    forever begin
      @(posedge clk);
      if (mem_re) re_cnt = re_cnt + 1;
      if (mem_we) begin
        we_cnt = we_cnt + 1;
        last_waddr = mem_addr;
        mem[mem_addr[7:2]] = mem_wdata;
      end
      if (mem_re && mem_we) both_cnt = both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_re, input int exp_we);
    int lat;
    int re0;
    int we0;
    re0 = re_cnt;
    we0 = we_cnt;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the DUT must have captured them.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_re"}, re_cnt - re0, exp_re);
    chk({tag, "_we"}, we_cnt - we0, exp_we);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    // Reset with a request held valid.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
    req_wdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    end
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_no_write", we_cnt, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

    // Word store then word load.
    do_req("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 32'd0, 0, 1);
    chk("sw_waddr", last_waddr, 32'h10);
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);
    do_req("lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2, 1'b0, 32'hDEAD_BEEF, 1, 0);

    // Byte RMW store and byte loads.
    do_req("sb", 1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 3, 1'b0, 32'd0, 1, 1);
    chk("sb_mem", mem[8], 32'h11AA_3344);
    do_req("lb_s", 1'b0, 2'b00, 1'b0, 32'h22, 32'd0, 2, 1'b0, 32'hFFFF_FFAA, 1, 0);
    do_req("lb_u", 1'b0, 2'b00, 1'b1, 32'h22, 32'd0, 2, 1'b0, 32'h0000_00AA, 1, 0);
    do_req("lb_pos", 1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 2, 1'b0, 32'h0000_0033, 1, 0);

    // Half RMW store and half loads.
    do_req("sh", 1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_8001, 3, 1'b0, 32'd0, 1, 1);
    chk("sh_mem", mem[9], 32'h8001_0000);
    do_req("lh_s", 1'b0, 2'b01, 1'b0, 32'h26, 32'd0, 2, 1'b0, 32'hFFFF_8001, 1, 0);
    do_req("lh_u", 1'b0, 2'b01, 1'b1, 32'h20, 32'd0, 2, 1'b0, 32'h0000_3344, 1, 0);

    // Error requests: respond in one cycle, no memory access, rdata 0.
    do_req("err_lw", 1'b0, 2'b10, 1'b0, 32'h13, 32'd0, 1, 1'b1, 32'd0, 0, 0);
    do_req("err_sh", 1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_BEEF, 1, 1'b1, 32'd0, 0, 0);
    do_req("err_sz", 1'b0, 2'b11, 1'b0, 32'h0, 32'd0, 1, 1'b1, 32'd0, 0, 0);
    chk("err_mem_addr_hold", mem_addr, 32'h20);

    // Reset during RMW_RD of a byte store aborts it.
    begin
      int we0;
      we0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h0000_0055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_in_rmw_rd", {31'd0, mem_re}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_we_gated", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      chk("abort_ready_rst", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      chk("abort_no_write", we_cnt - we0, 32'd0);
      chk("abort_mem", mem[8], 32'h11AA_3344);
    end

    chk("re_we_exclusive", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
